iomem_arbiter: RTL and testbench

Two-master arbiter that shares the PicoSoC iomem peripheral bus (GPIO/LED register block and later peripherals at 0x03xx_xxxx) between the CPU's iomem port and a second requester (debug/DMA master). It grants one master at a time with round-robin fairness and registers the granted request onto a single slave-side iomem bus. A bus watchdog completes any transaction the slave never acknowledges, so a missing peripheral cannot hang either master.

---
 rtl/iomem_arbiter.sv | 124 ++++++++++++
 tb/tb_iomem_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iomem_arbiter.sv
// rtl/iomem_arbiter.sv - round-robin two-master arbiter onto a registered iomem slave bus
// A bus watchdog force-completes any transfer the slave never acknowledges.
module iomem_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        m0_valid,
    input  logic [3:0]  m0_wstrb,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [3:0]  m1_wstrb,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic [3:0]  s_wstrb,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

    localparam logic [15:0] TC_LAST = 16'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        r_last;
    logic [15:0] r_tcnt;
    logic [3:0]  r_wstrb;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_valid;

    logic        w_start;
    logic        w_sel;
    logic        w_done;
    logic        w_tmo;
    logic [31:0] w_rdata;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_sel       = 1'b0;
        w_done      = 1'b0;
        w_tmo       = 1'b0;
        case (r_state)
            IDLE: begin
                if (m0_valid || m1_valid) begin
                    w_start     = 1'b1;
                    // On a tie the master that did not win last time goes next.
                    w_sel       = (m0_valid && m1_valid) ? ~r_last : m1_valid;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                w_done = s_ready || (r_tcnt == TC_LAST);
                w_tmo  = !s_ready && (r_tcnt == TC_LAST);
                if (w_done) begin
                    w_state_nxt = RELEASE;
                end
            end
            RELEASE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_owner <= 1'b0;
            r_last  <= 1'b1;
            r_tcnt  <= 16'd0;
            r_valid <= 1'b0;
            r_wstrb <= 4'd0;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
        end else if (w_start) begin
            r_owner <= w_sel;
            r_last  <= w_sel;
            r_tcnt  <= 16'd0;
            r_valid <= 1'b1;
            r_wstrb <= w_sel ? m1_wstrb : m0_wstrb;
            r_addr  <= w_sel ? m1_addr  : m0_addr;
            r_wdata <= w_sel ? m1_wdata : m0_wdata;
        end else if (r_state == BUSY) begin
            if (w_done) begin
                r_valid <= 1'b0;
            end else begin
                r_tcnt <= r_tcnt + 16'd1;
            end
        end
    end

    assign w_rdata     = w_tmo ? ERR_DATA : s_rdata;
    assign m0_rdata    = w_rdata;
    assign m1_rdata    = w_rdata;
    assign m0_ready    = w_done && !r_owner;
    assign m1_ready    = w_done && r_owner;
    assign timeout_err = w_tmo;
    assign grant       = (r_state == BUSY) ? {r_owner, !r_owner} : 2'b00;
    assign s_valid     = r_valid;
    assign s_wstrb     = r_wstrb;
    assign s_addr      = r_addr;
    assign s_wdata     = r_wdata;

endmodule

// File: tb/tb_iomem_arbiter.sv
// tb/tb_iomem_arbiter.sv - scoreboard bench for iomem_arbiter with a latency-programmable slave
// Stimulus pushes expected completions; an independent monitor pops them on each ready pulse.
module tb_iomem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        m0_valid = 1'b0, m1_valid = 1'b0;
    logic [3:0]  m0_wstrb = 4'd0, m1_wstrb = 4'd0;
    logic [31:0] m0_addr = 32'd0, m1_addr = 32'd0;
    logic [31:0] m0_wdata = 32'd0, m1_wdata = 32'd0;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [3:0]  s_wstrb;
    logic [31:0] s_addr, s_wdata;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'd0;
    logic [1:0]  grant;
    logic        timeout_err;

    iomem_arbiter #(.TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
        .clk(clk), .resetn(resetn),
        .m0_valid(m0_valid), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .grant(grant), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          m;
        logic [31:0] rdata;
        logic        terr;
        int          cyc;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave model: acks after slv_lat cycles of s_valid; rdata = base ^ addr low byte.
    int          slv_lat = 1;
    bit          slv_never = 1'b0;
    logic [31:0] slv_base = 32'd0;
    int          wcnt = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            s_ready = 1'b0;
            s_rdata = 32'd0;
            if (s_valid) begin
                if (!slv_never && wcnt == slv_lat) begin
                    s_ready = 1'b1;
                    s_rdata = slv_base ^ {24'd0, s_addr[7:0]};
                end
                wcnt++;
            end else begin
                wcnt = 0;
            end
        end
    end

    bit rel_pending = 1'b0;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rel_pending) begin
                chk("release_s_valid", {31'd0, s_valid}, 32'd0);
                chk("release_grant", {30'd0, grant}, 32'd0);
                rel_pending = 1'b0;
            end
            if (resetn && (m0_ready || m1_ready)) begin
                if (q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_ready: m0_ready=%b m1_ready=%b with empty scoreboard", m0_ready, m1_ready);
                end else begin
                    e = q.pop_front();
                    chk("sb_both_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
                    chk("sb_master", m1_ready ? 32'd1 : 32'd0, 32'(e.m));
                    chk("sb_rdata", m1_ready ? m1_rdata : m0_rdata, e.rdata);
                    chk("sb_timeout_err", {31'd0, timeout_err}, {31'd0, e.terr});
                    chk("sb_cycle", 32'(cyc), 32'(e.cyc));
                end
                rel_pending = 1'b1;
            end else if (timeout_err) begin
                n_vec++;
                n_err++;
                $display("FAIL stray_timeout_err: got 1 expected 0 outside a completion");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input logic [31:0] rd, input logic te, input int c);
        exp_t e;
        e.m = m; e.rdata = rd; e.terr = te; e.cyc = c;
        q.push_back(e);
    endtask

    task automatic wait_rdy(input int m, input int budget);
        bit got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if ((m == 0 && m0_ready) || (m == 1 && m1_ready)) got = 1'b1;
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL wait_m%0d_ready: got none expected a ready within %0d cycles", m, budget);
        end
    endtask

    task automatic wait_any(output int m, input int budget);
        bit got = 1'b0;
        m = -1;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (m0_ready || m1_ready) begin
                got = 1'b1;
                m = m1_ready ? 1 : 0;
            end
        end
        n_vec++;
        if (!got) begin
            n_err++;
            $display("FAIL wait_any_ready: got none expected a ready within %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int m;
        int cnt[2];

        // Reset state
        @(negedge clk);
        chk("rst_ctl", {26'd0, s_valid, grant, m0_ready, m1_ready, timeout_err}, 32'd0);
        chk("rst_addr", s_addr, 32'd0);
        chk("rst_wdata", s_wdata, 32'd0);
        chk("rst_wstrb", {28'd0, s_wstrb}, 32'd0);
        tick();
        tick();
        resetn = 1'b1;
        tick();

        // Single read from m0, registered slave
        slv_lat = 1; slv_never = 1'b0; slv_base = 32'h0000_0005;
        tick();
        c0 = cyc;
        m0_addr = 32'h0300_0000; m0_wstrb = 4'h0; m0_valid = 1'b1;
        push(0, 32'h0000_0005, 1'b0, c0 + 2);
        @(negedge clk);
        chk("t1_c0_s_valid", {31'd0, s_valid}, 32'd0);
        @(negedge clk);
        chk("t1_c1_s_valid", {31'd0, s_valid}, 32'd1);
        chk("t1_c1_grant", {30'd0, grant}, 32'd1);
        chk("t1_c1_s_addr", s_addr, 32'h0300_0000);
        chk("t1_c1_s_wstrb", {28'd0, s_wstrb}, 32'd0);
        wait_rdy(0, 20);
        chk("t1_c2_grant", {30'd0, grant}, 32'd1);
        tick();
        m0_valid = 1'b0;
        tick();
        @(negedge clk);
        chk("t1_c4_idle", {29'd0, s_valid, grant}, 32'd0);
        tick();

        // Write from m1
        slv_base = 32'd0;
        tick();
        c0 = cyc;
        m1_addr = 32'h0300_0000; m1_wdata = 32'h0000_0004; m1_wstrb = 4'hF; m1_valid = 1'b1;
        push(1, 32'd0, 1'b0, c0 + 2);
        @(negedge clk);
        @(negedge clk);
        chk("t2_s_wdata", s_wdata, 32'h0000_0004);
        chk("t2_s_wstrb", {28'd0, s_wstrb}, 32'h0000_000F);
        chk("t2_grant", {30'd0, grant}, 32'd2);
        wait_rdy(1, 20);
        tick();
        m1_valid = 1'b0; m1_wstrb = 4'h0;
        tick();
        tick();

        // Contention: combinational slave, both masters requesting, strict alternation
        slv_lat = 0; slv_base = 32'hA5A5_0000;
        tick();
        c0 = cyc;
        m0_addr = 32'h0300_0010; m1_addr = 32'h0300_0020;
        m0_valid = 1'b1; m1_valid = 1'b1;
        push(0, 32'hA5A5_0010, 1'b0, c0 + 1);
        push(1, 32'hA5A5_0020, 1'b0, c0 + 4);
        push(0, 32'hA5A5_0010, 1'b0, c0 + 7);
        push(1, 32'hA5A5_0020, 1'b0, c0 + 10);
        cnt[0] = 0; cnt[1] = 0;
        for (int k = 0; k < 4; k++) begin
            wait_any(m, 20);
            tick();
            if (m >= 0) begin
                cnt[m]++;
                if (cnt[m] == 2) begin
                    if (m == 0) m0_valid = 1'b0;
                    else m1_valid = 1'b0;
                end
            end
        end
        m0_valid = 1'b0; m1_valid = 1'b0;
        tick();
        tick();

        // Watchdog: slave never acks, forced completion at cycle 8
        slv_never = 1'b1;
        tick();
        c0 = cyc;
        m0_addr = 32'h0300_0100; m0_valid = 1'b1;
        push(0, 32'hDEAD_BEEF, 1'b1, c0 + 8);
        wait_rdy(0, 30);
        tick();
        m0_valid = 1'b0;
        tick();
        tick();

        // Slave ack on the last watchdog cycle wins over the timeout
        slv_never = 1'b0; slv_lat = 7; slv_base = 32'h1234_5678;
        tick();
        c0 = cyc;
        m1_addr = 32'h0300_0000; m1_valid = 1'b1;
        push(1, 32'h1234_5678, 1'b0, c0 + 8);
        wait_rdy(1, 30);
        tick();
        m1_valid = 1'b0;
        tick();
        tick();

        // Reset while BUSY abandons the transfer; pending m1 request is granted afterwards
        slv_never = 1'b1;
        tick();
        m1_addr = 32'h0300_0040; m1_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("t6_busy_s_valid", {31'd0, s_valid}, 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("t6_rst_ctl", {26'd0, s_valid, grant, m0_ready, m1_ready, timeout_err}, 32'd0);
        chk("t6_rst_addr", s_addr, 32'd0);
        slv_never = 1'b0; slv_lat = 1; slv_base = 32'h0000_0077;
        tick();
        tick();
        c0 = cyc;
        resetn = 1'b1;
        push(1, 32'h0000_0037, 1'b0, c0 + 2);
        wait_rdy(1, 20);
        tick();
        m1_valid = 1'b0;
        repeat (4) tick();

        chk("sb_drained", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
